// File: rtl/cordic_host_if.sv
// Request, engine (c_if) and response signals around cordic_host.
// master = cordic_host view; slave = the surrounding bus adapter / engine / consumer.
interface cordic_host_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_mode;
  logic [WIDTH-1:0] req_x;
  logic [WIDTH-1:0] req_y;
  logic [WIDTH-1:0] req_z;
  logic [TAG_W-1:0] req_tag;

  logic             c_valid_in;
  logic             c_mode;
  logic [WIDTH-1:0] c_x;
  logic [WIDTH-1:0] c_y;
  logic [WIDTH-1:0] c_z;
  logic             c_valid_out;
  logic [WIDTH-1:0] c_cos;
  logic [WIDTH-1:0] c_sin;
  logic [WIDTH-1:0] c_tan_in;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_a;
  logic [WIDTH-1:0] rsp_b;
  logic             rsp_mode;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    input  req_valid, req_mode, req_x, req_y, req_z, req_tag,
    output req_ready,
    output c_valid_in, c_mode, c_x, c_y, c_z,
    input  c_valid_out, c_cos, c_sin, c_tan_in,
    output rsp_valid, rsp_a, rsp_b, rsp_mode, rsp_tag, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_mode, req_x, req_y, req_z, req_tag,
    input  req_ready,
    input  c_valid_in, c_mode, c_x, c_y, c_z,
    output c_valid_out, c_cos, c_sin, c_tan_in,
    input  rsp_valid, rsp_a, rsp_b, rsp_mode, rsp_tag, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/cordic_host.sv
// Initiator for the iterative CORDIC engine: request FIFO, one-at-a-time issue,
// result capture with timeout, and a held ready/valid response.
//
//   state | meaning
//   IDLE  | waiting for a queued request; pops head into c_* registers
//   ISSUE | c_valid_in pulse (one cycle), timer cleared
//   WAIT  | timer running; capture on c_valid_out or error at TIMEOUT
//   HOLD  | rsp_valid high until rsp_ready
module cordic_host #(
  parameter int WIDTH      = 32,
  parameter int NUM_STAGES = 13,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = NUM_STAGES + 3,
  parameter int TAG_W      = 4
) (
  input  logic          clk,
  input  logic          rst,
  cordic_host_if.master bus,
  output logic          spurious
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic             mode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
    logic [TAG_W-1:0] tag;
  } req_t;

  state_t           state_q, state_d;
  req_t             fifo_q [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [TW-1:0]    timer;
  logic             c_mode_q;
  logic [WIDTH-1:0] c_x_q, c_y_q, c_z_q;
  logic [TAG_W-1:0] cur_tag;
  logic [WIDTH-1:0] rsp_a_q, rsp_b_q;
  logic             rsp_mode_q, rsp_err_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             push, pop, capture, time_out;
  logic             empty, full;
  req_t             head;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = fifo_q[rd_ptr];

  // Ready is held low while reset is asserted so no push is lost to the flush.
  assign bus.req_ready = !rst && !full;
  assign push          = bus.req_valid && bus.req_ready;

  assign bus.c_valid_in = (state_q == ISSUE);
  assign bus.c_mode     = c_mode_q;
  assign bus.c_x        = c_x_q;
  assign bus.c_y        = c_y_q;
  assign bus.c_z        = c_z_q;

  assign bus.rsp_valid  = (state_q == HOLD);
  assign bus.rsp_a      = rsp_a_q;
  assign bus.rsp_b      = rsp_b_q;
  assign bus.rsp_mode   = rsp_mode_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    capture  = 1'b0;
    time_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A strobe on the timeout cycle wins over the error.
        if (bus.c_valid_out) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (timer == TW'(TIMEOUT)) begin
          time_out = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{mode: bus.req_mode, x: bus.req_x, y: bus.req_y,
                                  z: bus.req_z, tag: bus.req_tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      timer      <= '0;
      c_mode_q   <= 1'b0;
      c_x_q      <= '0;
      c_y_q      <= '0;
      c_z_q      <= '0;
      cur_tag    <= '0;
      rsp_a_q    <= '0;
      rsp_b_q    <= '0;
      rsp_mode_q <= 1'b0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
      spurious   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        c_mode_q <= head.mode;
        c_x_q    <= head.x;
        c_y_q    <= head.y;
        c_z_q    <= head.z;
        cur_tag  <= head.tag;
      end
      count <= count + CW'(push) - CW'(pop);

      if (state_q == ISSUE)     timer <= '0;
      else if (state_q == WAIT) timer <= timer + TW'(1);

      if (capture) begin
        rsp_a_q    <= c_mode_q ? bus.c_cos : bus.c_tan_in;
        rsp_b_q    <= c_mode_q ? bus.c_sin : '0;
        rsp_err_q  <= 1'b0;
        rsp_mode_q <= c_mode_q;
        rsp_tag_q  <= cur_tag;
      end else if (time_out) begin
        rsp_a_q    <= '0;
        rsp_b_q    <= '0;
        rsp_err_q  <= 1'b1;
        rsp_mode_q <= c_mode_q;
        rsp_tag_q  <= cur_tag;
      end

      if (bus.c_valid_out && state_q != WAIT) spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_host.sv
// Directed bench for cordic_host with a fixed-latency stub engine.
module tb_cordic_host;
  localparam int WIDTH      = 32;
  localparam int NUM_STAGES = 13;
  localparam int DEPTH      = 4;
  localparam int TIMEOUT    = NUM_STAGES + 3;
  localparam int TAG_W      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spurious;

  cordic_host_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bif ();

  cordic_host #(
    .WIDTH(WIDTH), .NUM_STAGES(NUM_STAGES), .DEPTH(DEPTH),
    .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif),
    .spurious(spurious)
  );

  always #5 clk = ~clk;

  // Stub engine: result strobe sampled stub_delay edges after the accepting edge (0 = never).
  int   stub_delay = 0;
  int   stub_cnt   = 0;
  logic stub_vo    = 1'b0;
  logic man_vo     = 1'b0;

  assign bif.c_valid_out = stub_vo | man_vo;

  always @(posedge clk) begin
    stub_vo <= 1'b0;
    if (rst) stub_cnt <= 0;
    else if (bif.c_valid_in && stub_delay > 0) stub_cnt <= stub_delay - 1;
    else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_vo <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic mode, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic [WIDTH-1:0] z, input logic [TAG_W-1:0] tag);
    int k;
    bif.req_valid = 1'b1;
    bif.req_mode  = mode;
    bif.req_x     = x;
    bif.req_y     = y;
    bif.req_z     = z;
    bif.req_tag   = tag;
    k = 0;
    while (!bif.req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("push_timeout", 64'(k), 64'(0));
    @(negedge clk);
    bif.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int vin);
    int n, first;
    n = 0; first = -1; vin = 0;
    while (!bif.rsp_valid && n < 200) begin
      if (bif.c_valid_in) begin
        vin++;
        if (first < 0) first = n;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("rsp_wait_timeout", 64'(n), 64'(0));
    lat = n - first;
  endtask

  task automatic release_rsp();
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    bif.rsp_ready = 1'b0;
    check("rsp_valid_after_release", 64'(bif.rsp_valid), 64'(0));
  endtask

  initial begin
    int lat, vin, seen;
    bif.req_valid = 1'b0; bif.req_mode = 1'b0;
    bif.req_x = '0; bif.req_y = '0; bif.req_z = '0; bif.req_tag = '0;
    bif.rsp_ready = 1'b0;
    bif.c_cos = 32'h1111; bif.c_sin = 32'h2222; bif.c_tan_in = 32'h0ABC;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(bif.req_ready), 64'(0));
    check("rst_c_valid_in", 64'(bif.c_valid_in), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(bif.req_ready), 64'(1));
    check("post_rst_rsp_valid", 64'(bif.rsp_valid), 64'(0));
    check("post_rst_c_x", 64'(bif.c_x), 64'(0));
    check("post_rst_rsp_a", 64'(bif.rsp_a), 64'(0));
    check("post_rst_spurious", 64'(spurious), 64'(0));

    // single sin/cos
    stub_delay = 12;
    push(1'b1, 32'd0, 32'd0, 32'h0000_4000, 4'd3);
    wait_rsp(lat, vin);
    check("sc_latency", 64'(lat), 64'(NUM_STAGES));
    check("sc_vin_cycles", 64'(vin), 64'(1));
    check("sc_rsp_a", 64'(bif.rsp_a), 64'h1111);
    check("sc_rsp_b", 64'(bif.rsp_b), 64'h2222);
    check("sc_tag", 64'(bif.rsp_tag), 64'(3));
    check("sc_mode", 64'(bif.rsp_mode), 64'(1));
    check("sc_err", 64'(bif.rsp_err), 64'(0));
    check("sc_c_z_held", 64'(bif.c_z), 64'h4000);
    release_rsp();

    // single arctan
    push(1'b0, 32'd5, 32'hFFFF_FFFB, 32'd0, 4'd7);
    wait_rsp(lat, vin);
    check("at_rsp_a", 64'(bif.rsp_a), 64'h0ABC);
    check("at_rsp_b", 64'(bif.rsp_b), 64'(0));
    check("at_mode", 64'(bif.rsp_mode), 64'(0));
    check("at_tag", 64'(bif.rsp_tag), 64'(7));
    check("at_c_y", 64'(bif.c_y), 64'hFFFF_FFFB);
    release_rsp();

    // back-pressure and full FIFO
    for (int i = 0; i < 5; i++) push(1'b1, 32'(i), 32'd0, 32'd0, 4'(i));
    check("full_req_ready", 64'(bif.req_ready), 64'(0));
    bif.req_valid = 1'b1; bif.req_tag = 4'd5;
    repeat (3) begin
      check("full_refuse", 64'(bif.req_ready), 64'(0));
      @(negedge clk);
    end
    bif.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(lat, vin);
      check("bp_tag", 64'(bif.rsp_tag), 64'(i));
      check("bp_rsp_a", 64'(bif.rsp_a), 64'h1111);
      repeat (3) begin
        @(negedge clk);
        if (bif.c_valid_in && bif.rsp_valid) viol++;
        check("bp_hold_valid", 64'(bif.rsp_valid), 64'(1));
        check("bp_hold_tag", 64'(bif.rsp_tag), 64'(i));
        check("bp_hold_b", 64'(bif.rsp_b), 64'h2222);
      end
      release_rsp();
    end
    check("bp_issue_in_hold", 64'(viol), 64'(0));
    check("bp_req_ready_again", 64'(bif.req_ready), 64'(1));
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bif.rsp_valid || bif.c_valid_in) seen++;
    end
    check("bp_no_sixth", 64'(seen), 64'(0));

    // timeout with no strobe
    stub_delay = 0;
    push(1'b1, 32'd0, 32'd0, 32'd1, 4'd9);
    wait_rsp(lat, vin);
    check("to_latency", 64'(lat), 64'(TIMEOUT + 2));
    check("to_err", 64'(bif.rsp_err), 64'(1));
    check("to_rsp_a", 64'(bif.rsp_a), 64'(0));
    check("to_rsp_b", 64'(bif.rsp_b), 64'(0));
    check("to_tag", 64'(bif.rsp_tag), 64'(9));
    release_rsp();

    // strobe exactly on the timeout cycle
    stub_delay = TIMEOUT + 1;
    push(1'b1, 32'd0, 32'd0, 32'd2, 4'd10);
    wait_rsp(lat, vin);
    check("edge_latency", 64'(lat), 64'(TIMEOUT + 2));
    check("edge_err", 64'(bif.rsp_err), 64'(0));
    check("edge_rsp_a", 64'(bif.rsp_a), 64'h1111);
    release_rsp();
    check("pre_spurious", 64'(spurious), 64'(0));

    // spurious strobe while idle
    repeat (2) @(negedge clk);
    man_vo = 1'b1;
    @(negedge clk);
    man_vo = 1'b0;
    check("spurious_set", 64'(spurious), 64'(1));
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bif.rsp_valid) seen++;
    end
    check("spurious_no_rsp", 64'(seen), 64'(0));
    check("spurious_sticky", 64'(spurious), 64'(1));

    // reset during WAIT with two requests queued
    stub_delay = 12;
    push(1'b1, 32'd0, 32'd0, 32'd3, 4'd11);
    push(1'b1, 32'd0, 32'd0, 32'd4, 4'd12);
    push(1'b1, 32'd0, 32'd0, 32'd5, 4'd13);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 64'(bif.req_ready), 64'(0));
    rst = 1'b0;
    check("mid_rst_c_z", 64'(bif.c_z), 64'(0));
    check("mid_rst_rsp_tag", 64'(bif.rsp_tag), 64'(0));
    check("mid_rst_rsp_a", 64'(bif.rsp_a), 64'(0));
    check("mid_rst_spurious", 64'(spurious), 64'(0));
    check("mid_rst_c_valid_in", 64'(bif.c_valid_in), 64'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bif.rsp_valid || bif.c_valid_in) seen++;
    end
    check("mid_rst_flushed", 64'(seen), 64'(0));
    check("mid_rst_no_spurious", 64'(spurious), 64'(0));
    push(1'b1, 32'd0, 32'd0, 32'd6, 4'd14);
    wait_rsp(lat, vin);
    check("after_rst_latency", 64'(lat), 64'(NUM_STAGES));
    check("after_rst_tag", 64'(bif.rsp_tag), 64'(14));
    check("after_rst_c_z", 64'(bif.c_z), 64'(6));
    release_rsp();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cordic_host.md
# cordic_host

Initiator-side controller for the iterative CORDIC engine's `c_if` protocol. It buffers incoming angle/vector requests in a small FIFO and issues them to the engine one at a time as a single-cycle `valid_in` pulse. It captures the engine's one-cycle `valid_out` result and returns it on a ready/valid response port. It sits between the system bus adapter and the single-stage CORDIC; the engine cannot stall its output, so this block owns all flow control.

## Interface
- `WIDTH`, 32: data width of x/y/z and results (two's complement).
- `NUM_STAGES`, 13: must equal the engine's `NUM_STAGES`; the engine raises `valid_out` NUM_STAGES-1 cycles after accepting `valid_in`.
- `DEPTH`, 4: request FIFO entries (power of two, ≥2).
- `TIMEOUT`, NUM_STAGES+3: max cycles from issue to `valid_out` before error.
- `TAG_W`, 4: request tag width.

Ports:
- `clk`  in  1  single clock, shared with the engine.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  FIFO not full.
- `req_mode`  in  1  0 = arctan (vectoring), 1 = sin/cos (rotation).
- `req_x`, `req_y`, `req_z`  in  WIDTH each  operands.
- `req_tag`  in  TAG_W  opaque ID, returned with the response.
- `c_valid_in`  out  1  issue pulse to the engine.
- `c_mode`  out  1  to the engine.
- `c_x`, `c_y`, `c_z`  out  WIDTH each  to the engine.
- `c_valid_out`  in  1  engine result strobe, one cycle.
- `c_cos`, `c_sin`, `c_tan_in`  in  WIDTH each  engine results, valid only while `c_valid_out`=1.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_a`  out  WIDTH  mode 1: cos; mode 0: angle (`c_tan_in`).
- `rsp_b`  out  WIDTH  mode 1: sin; mode 0: 0.
- `rsp_mode`, `rsp_tag`  out  1, TAG_W  echoed from the request.
- `rsp_err`  out  1  timeout; `rsp_a`/`rsp_b` are 0.
- `spurious`  out  1  sticky: `c_valid_out` was seen outside WAIT.

## Operation
- Request FIFO: push on `req_valid && req_ready`; `req_ready = !full`. The FIFO has no bypass path.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if the FIFO is non-empty, pop the head into the registered `c_*` outputs, then go to ISSUE.
- ISSUE (exactly 1 cycle): `c_valid_in`=1, then go to WAIT and clear the timer. `c_mode`/`c_x`/`c_y`/`c_z` hold their values until the next issue.
- WAIT: the timer increments each cycle.
  - On `c_valid_out`=1: capture into the response registers. Mode 1: `rsp_a`=`c_cos`, `rsp_b`=`c_sin`. Mode 0: `rsp_a`=`c_tan_in`, `rsp_b`=0. Set `rsp_err`=0 and go to HOLD.
  - If the timer reaches TIMEOUT with no strobe: set `rsp_err`=1, `rsp_a`=`rsp_b`=0, and go to HOLD.
  - A `c_valid_out` on the same cycle as the timeout counts as a valid result, not an error.
- HOLD: `rsp_valid`=1. On `rsp_ready`, go to IDLE. Response fields stay stable while `rsp_valid && !rsp_ready`.
- `c_valid_out` in IDLE, ISSUE or HOLD is ignored (no capture) and sets `spurious`.
- Only one request is in flight at a time. `c_valid_in` is never asserted outside ISSUE.

## Timing
- Reset values: `req_ready`=0 during reset and 1 on the first cycle after. `c_valid_in`=0, `c_mode`=0, `c_x`/`c_y`/`c_z`=0. `rsp_valid`=0, `rsp_a`/`rsp_b`/`rsp_tag`/`rsp_mode`=0, `rsp_err`=0, `spurious`=0. FSM=IDLE, FIFO empty.
- Cycle sequence for a request pushed at edge E0:
  - IDLE sees non-empty at E0+1, pops.
  - ISSUE (`c_valid_in`=1) runs for cycle E0+1→E0+2.
  - `c_valid_out` arrives NUM_STAGES-1 cycles later.
  - `rsp_valid` rises on the following edge.
- Minimum issue-to-issue interval: NUM_STAGES+2 cycles when `rsp_ready`=1.
- Reset mid-operation: the FIFO is flushed, any in-flight or held response is dropped, and no response is ever produced for it. The top level resets the engine in the same cycle.
- Full FIFO: a push is refused even if a pop happens in the same cycle.

## Test plan
- Single sin/cos: mode 1, z=0x0000_4000, tag 3; stub engine returns cos=0x1111, sin=0x2222 after 12 cycles → `c_valid_in` is high exactly 1 cycle; `rsp_a`=0x1111, `rsp_b`=0x2222, tag 3, err 0; `rsp_valid` rises exactly NUM_STAGES cycles after the ISSUE cycle.
- Single arctan: mode 0, x=5, y=−5; stub `c_tan_in`=0x0ABC → `rsp_a`=0x0ABC, `rsp_b`=0, mode 0.
- Back-pressure plus full FIFO: push 5 requests with `rsp_ready`=0 → `req_ready` drops after 4 pushes plus the 1 popped request. Each response holds stable until released. Tags come out in order 0..4, and `c_valid_in` is never asserted while in HOLD.
- Timeout: the stub never strobes → after TIMEOUT cycles, `rsp_valid`=1 with `rsp_err`=1 and zeros. A strobe on exactly the TIMEOUT cycle gives `rsp_err`=0.
- Spurious strobe: pulse `c_valid_out` while IDLE → no response is produced and `spurious`=1 until `rst`.
- Reset during WAIT with 2 requests queued → all outputs return to reset values next cycle; no response is produced; the next push is issued normally.
